wave_sequencer: RTL and testbench

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

---
 rtl/wave_sequencer_pkg.sv | 33 +++
 rtl/wave_sequencer_if.sv | 24 ++
 rtl/wave_sequencer_unit_timer.sv | 35 +++
 rtl/wave_sequencer.sv | 130 +++++++++++++
 tb/tb_wave_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wave_sequencer_pkg.sv
// Shared types and constants for the wave sequencer: state encoding,
// program-entry field layout and the default unit divider.
package wave_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int CFG_W        = 12;
  localparam int FLD_W        = 4;
  localparam int REPS_LSB     = 8;
  localparam int M_LSB        = 4;
  localparam int N_LSB        = 0;
  localparam int TICK_DIV_DEF = 10;

  typedef struct packed {
    logic [FLD_W-1:0] reps;
    logic [FLD_W-1:0] m;
    logic [FLD_W-1:0] n;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [CFG_W-1:0] d);
    entry_t e;
    e.reps = d[REPS_LSB +: FLD_W];
    e.m    = d[M_LSB +: FLD_W];
    e.n    = d[N_LSB +: FLD_W];
    return e;
  endfunction

endpackage

// File: rtl/wave_sequencer_if.sv
// Config/control/status bundle between a host and the wave sequencer.
interface wave_sequencer_if;
  logic        cfgWe;
  logic [1:0]  cfgAddr;
  logic [11:0] cfgData;
  logic        start;
  logic        stop;
  logic        busy;
  logic [1:0]  step;
  logic [3:0]  m;
  logic [3:0]  n;
  logic        waveOut;
  logic        done;

  modport master (
    output cfgWe, cfgAddr, cfgData, start, stop,
    input  busy, step, m, n, waveOut, done
  );

  modport slave (
    input  cfgWe, cfgAddr, cfgData, start, stop,
    output busy, step, m, n, waveOut, done
  );
endinterface

// File: rtl/wave_sequencer_unit_timer.sv
// Phase timer: restart loads count*TICK_DIV, expire_o is high on the last
// clock of that window so the owner changes phase exactly on its boundary.
module unit_timer
  import wave_sequencer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  input  logic [3:0] count_i,
  output logic       expire_o
);

  localparam int CW = $clog2(15 * TICK_DIV + 1) < 4 ? 4 : $clog2(15 * TICK_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic          run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (restart_i) begin
      cnt_q <= CW'(count_i) * CW'(TICK_DIV) - CW'(1);
      run_q <= (count_i != 4'd0);
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/wave_sequencer.sv
// Programmable four-step PWM sequencer: each entry plays reps periods of
// m units high then n units low; entries with nothing to play are skipped.
module wave_sequencer
  import wave_sequencer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int STEPS    = 4
) (
  input  logic             clk,
  input  logic             reset,
  wave_sequencer_if.slave  bus
);

  state_e          state_q;
  logic [1:0]      step_q;
  logic [3:0]      m_q, n_q, rep_q;
  logic            busy_q, wave_q, done_q, go_q;
  logic [CFG_W-1:0] prog_q [STEPS];

  entry_t     cur;
  logic       ld_ok, hi_end, period_end, advance, abort;
  logic       tmr_restart, tmr_exp;
  logic [3:0] tmr_cnt;

  assign cur        = unpack_entry(prog_q[step_q]);
  assign ld_ok      = (cur.reps != 4'd0) && ((cur.m != 4'd0) || (cur.n != 4'd0));
  assign hi_end     = (state_q == HIGH) && tmr_exp;
  assign period_end = (hi_end && (n_q == 4'd0)) || ((state_q == LOW) && tmr_exp);
  assign advance    = ((state_q == LOAD) && !ld_ok) || (period_end && (rep_q == 4'd1));
  assign abort      = bus.stop && (state_q != IDLE);

  // Timer restarts on every phase entry so phases never inherit leftover ticks.
  always_comb begin
    tmr_restart = 1'b0;
    tmr_cnt     = (m_q != 4'd0) ? m_q : n_q;
    if (!abort) begin
      if ((state_q == LOAD) && ld_ok) begin
        tmr_restart = 1'b1;
        tmr_cnt     = (cur.m != 4'd0) ? cur.m : cur.n;
      end else if (hi_end && (n_q != 4'd0)) begin
        tmr_restart = 1'b1;
        tmr_cnt     = n_q;
      end else if (period_end && (rep_q != 4'd1)) begin
        tmr_restart = 1'b1;
      end
    end
  end

  unit_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart_i(tmr_restart),
    .count_i  (tmr_cnt),
    .expire_o (tmr_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      m_q     <= 4'd0;
      n_q     <= 4'd0;
      rep_q   <= 4'd0;
      busy_q  <= 1'b0;
      wave_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      for (int i = 0; i < STEPS; i++) prog_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      // start is captured one edge before the FSM leaves IDLE
      go_q   <= bus.start && !bus.stop && (state_q == IDLE);
      if (bus.cfgWe && !busy_q) prog_q[bus.cfgAddr] <= bus.cfgData;

      if (abort) begin
        state_q <= IDLE;
        step_q  <= 2'd0;
        busy_q  <= 1'b0;
        wave_q  <= 1'b0;
      end else if (advance) begin
        if (state_q == LOAD) begin
          m_q   <= cur.m;
          n_q   <= cur.n;
          rep_q <= cur.reps;
        end
        wave_q <= 1'b0;
        if (step_q == 2'(STEPS - 1)) begin
          state_q <= IDLE;
          step_q  <= 2'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= LOAD;
          step_q  <= step_q + 2'd1;
        end
      end else if (period_end) begin
        rep_q   <= rep_q - 4'd1;
        state_q <= (m_q != 4'd0) ? HIGH : LOW;
        wave_q  <= (m_q != 4'd0);
      end else begin
        case (state_q)
          IDLE: if (go_q && !bus.stop) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
          LOAD: begin
            m_q     <= cur.m;
            n_q     <= cur.n;
            rep_q   <= cur.reps;
            state_q <= (cur.m != 4'd0) ? HIGH : LOW;
            wave_q  <= (cur.m != 4'd0);
          end
          HIGH: if (hi_end) begin
            state_q <= LOW;
            wave_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.step    = step_q;
  assign bus.m       = m_q;
  assign bus.n       = n_q;
  assign bus.waveOut = wave_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer at TICK_DIV=2; one task per scenario.
module tb_wave_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       wv [0:127];
  logic       bz [0:127];
  logic       dn [0:127];
  logic [1:0] st [0:127];
  logic [3:0] mm [0:127];
  logic [3:0] nn [0:127];

  wave_sequencer_if bus();

  wave_sequencer #(.TICK_DIV(2), .STEPS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [11:0] d);
    bus.cfgWe = 1'b1; bus.cfgAddr = a; bus.cfgData = d;
    tick();
    bus.cfgWe = 1'b0;
  endtask

  // Pulses start, then records outputs after each edge; sample 0 follows the start edge.
  // At sample inj a write to entry0 and a second start are attempted for one cycle.
  task automatic capture(input int n, input int inj);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) tick();
      wv[i] = bus.waveOut; bz[i] = bus.busy; dn[i] = bus.done;
      st[i] = bus.step;    mm[i] = bus.m;    nn[i] = bus.n;
      if (i == inj) begin
        bus.cfgWe = 1'b1; bus.cfgAddr = 2'd0; bus.cfgData = 12'h1F0; bus.start = 1'b1;
      end else if (i == inj + 1) begin
        bus.cfgWe = 1'b0; bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cfgWe = 1'b0; bus.cfgAddr = 2'd0; bus.cfgData = 12'h000;
    bus.start = 1'b0; bus.stop = 1'b0;
    #12;
    n_cmp++;
    if ({bus.busy, bus.waveOut, bus.done, bus.step, bus.m, bus.n} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b wave=%b done=%b step=%0d m=%0d n=%0d want all 0",
               bus.busy, bus.waveOut, bus.done, bus.step, bus.m, bus.n);
    end
    #4 reset = 1'b1;
    tick();
  endtask

  task automatic test_single_entry();
    int highs;
    int dones;
    write_entry(2'd0, 12'h294);
    for (int a = 1; a < 4; a++) write_entry(2'(a), 12'h000);
    capture(62, -1);
    highs = 0; dones = 0;
    for (int i = 0; i <= 62; i++) begin
      logic ew, eb, ed;
      ew = ((i >= 2) && (i <= 19)) || ((i >= 28) && (i <= 45));
      eb = (i >= 1) && (i <= 56);
      ed = (i == 57);
      if (wv[i]) highs++;
      if (dn[i]) dones++;
      n_cmp++;
      if ({wv[i], bz[i], dn[i]} !== {ew, eb, ed}) begin
        n_bad++;
        $display("FAIL single_cycle%0d got wave/busy/done=%b%b%b want %b%b%b", i, wv[i], bz[i], dn[i], ew, eb, ed);
      end
    end
    n_cmp++;
    if (highs !== 36) begin n_bad++; $display("FAIL single_high_count got %0d want 36", highs); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL single_done_count got %0d want 1", dones); end
    n_cmp++;
    if ({mm[2], nn[2]} !== {4'd9, 4'd4}) begin
      n_bad++; $display("FAIL single_mn got m=%0d n=%0d want 9 4", mm[2], nn[2]);
    end
    n_cmp++;
    if ({st[54], st[55], st[56], st[57]} !== {2'd1, 2'd2, 2'd3, 2'd0}) begin
      n_bad++; $display("FAIL single_skip_steps got %0d %0d %0d %0d want 1 2 3 0", st[54], st[55], st[56], st[57]);
    end
  endtask

  task automatic test_multi_entry();
    logic [21:0] exp_w;
    exp_w = 22'b0;
    exp_w[2] = 1'b1; exp_w[3] = 1'b1;
    exp_w[7] = 1'b1; exp_w[8] = 1'b1; exp_w[9] = 1'b1; exp_w[10] = 1'b1;
    write_entry(2'd0, 12'h111);
    write_entry(2'd1, 12'h120);
    write_entry(2'd2, 12'h055);
    write_entry(2'd3, 12'h103);
    capture(21, -1);
    for (int i = 0; i <= 21; i++) begin
      n_cmp++;
      if ({wv[i], bz[i], dn[i]} !== {exp_w[i], (i >= 1) && (i <= 18), i == 19}) begin
        n_bad++;
        $display("FAIL multi_cycle%0d got wave/busy/done=%b%b%b want %b%b%b", i, wv[i], bz[i], dn[i],
                 exp_w[i], (i >= 1) && (i <= 18), i == 19);
      end
    end
    n_cmp++;
    if ({st[6], st[11], st[12], st[13]} !== {2'd1, 2'd2, 2'd3, 2'd3}) begin
      n_bad++; $display("FAIL multi_steps got %0d %0d %0d %0d want 1 2 3 3", st[6], st[11], st[12], st[13]);
    end
    n_cmp++;
    if ({mm[7], nn[7], mm[13], nn[13]} !== {4'd2, 4'd0, 4'd0, 4'd3}) begin
      n_bad++; $display("FAIL multi_mn got %0d/%0d %0d/%0d want 2/0 0/3", mm[7], nn[7], mm[13], nn[13]);
    end
    n_cmp++;
    if ({mm[21], nn[21]} !== {4'd0, 4'd3}) begin
      n_bad++; $display("FAIL multi_idle_hold got m=%0d n=%0d want 0 3", mm[21], nn[21]);
    end
  endtask

  task automatic test_stop();
    int seen;
    write_entry(2'd0, 12'h294);
    for (int a = 1; a < 4; a++) write_entry(2'(a), 12'h000);
    capture(30, -1);
    n_cmp++;
    if ({wv[30], bz[30]} !== 2'b11) begin
      n_bad++; $display("FAIL stop_pre got wave=%b busy=%b want 1 1", wv[30], bz[30]);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_cmp++;
    if ({bus.waveOut, bus.busy, bus.step, bus.done} !== 5'b0) begin
      n_bad++; $display("FAIL stop_abort got wave=%b busy=%b step=%0d done=%b want 0", bus.waveOut, bus.busy, bus.step, bus.done);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL stop_quiet got %0d active cycles want 0", seen); end
  endtask

  task automatic test_busy_write();
    int seen;
    write_entry(2'd0, 12'h111);
    for (int a = 1; a < 4; a++) write_entry(2'(a), 12'h000);
    capture(12, 2);
    for (int i = 0; i <= 12; i++) begin
      n_cmp++;
      if ({wv[i], dn[i]} !== {(i == 2) || (i == 3), i == 9}) begin
        n_bad++; $display("FAIL busywr_run1_cycle%0d got wave=%b done=%b want %b %b", i, wv[i], dn[i], (i == 2) || (i == 3), i == 9);
      end
    end
    n_cmp++;
    if ({bz[8], bz[10], bz[12]} !== 3'b100) begin
      n_bad++; $display("FAIL busywr_restart got busy=%b%b%b want 100", bz[8], bz[10], bz[12]);
    end
    capture(12, -1);
    n_cmp++;
    if ({mm[3], wv[3], wv[4], dn[9]} !== {4'd1, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL busywr_run2 got m=%0d wave3=%b wave4=%b done9=%b want 1 1 0 1", mm[3], wv[3], wv[4], dn[9]);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.busy) seen++; end
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.busy) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL start_stop_idle got %0d busy cycles want 0", seen); end
  endtask

  task automatic test_async_reset();
    write_entry(2'd0, 12'h294);
    capture(22, -1);
    n_cmp++;
    if ({wv[22], bz[22]} !== 2'b01) begin
      n_bad++; $display("FAIL areset_pre got wave=%b busy=%b want 0 1", wv[22], bz[22]);
    end
    bus.stop = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.waveOut, bus.done, bus.step, bus.m, bus.n} !== 13'd0) begin
      n_bad++; $display("FAIL areset_immediate got busy=%b wave=%b step=%0d m=%0d n=%0d want 0",
                        bus.busy, bus.waveOut, bus.step, bus.m, bus.n);
    end
    tick();
    reset = 1'b1;
    tick();
    capture(8, -1);
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if ({wv[i], bz[i], dn[i]} !== {1'b0, (i >= 1) && (i <= 4), i == 5}) begin
        n_bad++; $display("FAIL areset_skip_cycle%0d got wave/busy/done=%b%b%b want 0%b%b", i, wv[i], bz[i], dn[i],
                          (i >= 1) && (i <= 4), i == 5);
      end
    end
    n_cmp++;
    if ({st[1], st[4]} !== {2'd0, 2'd3}) begin
      n_bad++; $display("FAIL areset_steps got %0d %0d want 0 3", st[1], st[4]);
    end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_multi_entry();
    test_stop();
    test_busy_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
